// File: rtl/cndm_micro_dp_ctrl_pkg.sv
// Shared definitions for the per-port datapath control APB completer:
// register map, FSM states and the per-queue register bundle.
package cndm_micro_dp_ctrl_pkg;

    localparam logic [15:0] ID_VERSION = 16'h0001;

    localparam int REG_ID   = 'h0000;
    localparam int Q_BASE   = 'h0100;
    localparam int Q_STRIDE = 'h20;
    localparam int Q_SHIFT  = $clog2(Q_STRIDE);

    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_BASE_LO = 5'h04;
    localparam logic [4:0] OFF_BASE_HI = 5'h08;
    localparam logic [4:0] OFF_PROD    = 5'h0C;
    localparam logic [4:0] OFF_CONS    = 5'h10;

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  log_size;
        logic [63:0] base_addr;
        logic [15:0] prod;
    } qreg_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wd,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/cndm_micro_dp_ctrl_qregs.sv
// One queue's register set: write checks, base-address lock while enabled,
// and the doorbell pulse. Byte-lane writes when CNDM_DP_CTRL_PSTRB_EN is defined.
module cndm_micro_dp_ctrl_qregs
    import cndm_micro_dp_ctrl_pkg::*;
#(
    parameter int MAX_LOG_SIZE = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic [4:0]  off,
    input  logic [31:0] wdata,
    input  logic [3:0]  strb,
    output qreg_t       regs,
    output logic        doorbell,
    output logic        err
);

    logic [3:0] be;
    logic       commit;

`ifdef CNDM_DP_CTRL_PSTRB_EN
    assign be = strb;
`else
    // Strobes are ignored: every write is a full word.
    assign be = strb | 4'hF;
`endif

    // A write with no lanes enabled touches nothing, so it can never fault.
    assign err = (|be) &&
                 ((off == OFF_CTRL && be[2] && wdata[19:16] > 4'(MAX_LOG_SIZE)) ||
                  ((off == OFF_BASE_LO || off == OFF_BASE_HI) && regs.en));

    assign commit = wr && !err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '0;
            doorbell <= 1'b0;
        end else begin
            doorbell <= commit && off == OFF_PROD && (|be[1:0]);
            if (commit) begin
                case (off)
                    OFF_CTRL: begin
                        if (be[0]) regs.en       <= wdata[0];
                        if (be[2]) regs.log_size <= wdata[19:16];
                    end
                    OFF_BASE_LO: regs.base_addr[31:0]  <= merge_bytes(regs.base_addr[31:0], wdata, be);
                    OFF_BASE_HI: regs.base_addr[63:32] <= merge_bytes(regs.base_addr[63:32], wdata, be);
                    OFF_PROD: begin
                        if (be[0]) regs.prod[7:0]  <= wdata[7:0];
                        if (be[1]) regs.prod[15:8] <= wdata[15:8];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/cndm_micro_dp_ctrl_apb.sv
// APB completer for one port's queue control registers; feeds queue engines
// with config and doorbells. Optional byte strobes: CNDM_DP_CTRL_PSTRB_EN.
module cndm_micro_dp_ctrl_apb
    import cndm_micro_dp_ctrl_pkg::*;
#(
    parameter int QUEUES       = 2,
    parameter int ADDR_W       = 16,
    parameter int WAIT_STATES  = 1,
    parameter int MAX_LOG_SIZE = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    s_apb_paddr,
    input  logic                 s_apb_psel,
    input  logic                 s_apb_penable,
    input  logic                 s_apb_pwrite,
    input  logic [31:0]          s_apb_pwdata,
    input  logic [3:0]           s_apb_pstrb,
    output logic [31:0]          s_apb_prdata,
    output logic                 s_apb_pready,
    output logic                 s_apb_pslverr,
    output logic [QUEUES-1:0]    q_en,
    output logic [QUEUES*4-1:0]  q_log_size,
    output logic [QUEUES*64-1:0] q_base_addr,
    output logic [QUEUES*16-1:0] q_prod,
    output logic [QUEUES-1:0]    q_doorbell,
    input  logic [QUEUES*16-1:0] q_cons
);

    state_t            state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic              setup, pready;
    logic [ADDR_W-1:0] addr_q, word, rel;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        setup    = 1'b0;
        pready   = 1'b0;
        case (state)
            IDLE: begin
                if (s_apb_psel && !s_apb_penable) begin
                    setup    = 1'b1;
                    cnt_nx   = 2'(WAIT_STATES);
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                // Losing psel mid-transfer abandons it without a response.
                if (!s_apb_psel)       state_nx = IDLE;
                else if (cnt != 2'd0)  cnt_nx   = cnt - 2'd1;
                else if (s_apb_penable) begin
                    pready   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (setup) begin
                addr_q  <= s_apb_paddr;
                write_q <= s_apb_pwrite;
                wdata_q <= s_apb_pwdata;
                strb_q  <= s_apb_pstrb;
            end
        end
    end

    logic [4:0]        off;
    logic              is_id;
    logic              in_q;
    logic [QUEUES-1:0] hit, qerr;
    qreg_t             regs [QUEUES];

    assign word  = addr_q & ~ADDR_W'(3);
    assign rel   = word - ADDR_W'(Q_BASE);
    assign off   = rel[Q_SHIFT-1:0];
    assign is_id = (word == ADDR_W'(REG_ID));
    assign in_q  = (word >= ADDR_W'(Q_BASE)) && (off <= OFF_CONS);

    for (genvar g = 0; g < QUEUES; g++) begin : g_q
        assign hit[g] = in_q && (rel[ADDR_W-1:Q_SHIFT] == (ADDR_W-Q_SHIFT)'(g));

        cndm_micro_dp_ctrl_qregs #(.MAX_LOG_SIZE(MAX_LOG_SIZE)) u_qregs (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr       (pready && write_q && hit[g] && off != OFF_CONS),
            .off      (off),
            .wdata    (wdata_q),
            .strb     (strb_q),
            .regs     (regs[g]),
            .doorbell (q_doorbell[g]),
            .err      (qerr[g])
        );

        assign q_en[g]               = regs[g].en;
        assign q_log_size[g*4 +: 4]  = regs[g].log_size;
        assign q_base_addr[g*64 +: 64] = regs[g].base_addr;
        assign q_prod[g*16 +: 16]    = regs[g].prod;
    end

    logic [31:0] rdata;
    logic        mapped, ro, err;

    always_comb begin
        rdata = '0;
        if (is_id) rdata = {16'(QUEUES), ID_VERSION};
        for (int q = 0; q < QUEUES; q++) begin
            if (hit[q]) begin
                case (off)
                    OFF_CTRL:    rdata = {12'h0, regs[q].log_size, 15'h0, regs[q].en};
                    OFF_BASE_LO: rdata = regs[q].base_addr[31:0];
                    OFF_BASE_HI: rdata = regs[q].base_addr[63:32];
                    OFF_PROD:    rdata = {16'h0, regs[q].prod};
                    default:     rdata = {16'h0, q_cons[q*16 +: 16]};
                endcase
            end
        end
    end

    assign mapped = is_id || (|hit);
    assign ro     = is_id || off == OFF_CONS;
    assign err    = !mapped || (write_q && (ro || (|(hit & qerr))));

    assign s_apb_pready  = pready;
    assign s_apb_pslverr = pready && err;
    assign s_apb_prdata  = (pready && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_cndm_micro_dp_ctrl_apb.sv
// Directed bench for the datapath control completer: the stimulus pushes
// expected responses, a negedge monitor pops and compares on pready.
module tb_cndm_micro_dp_ctrl_apb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  paddr = '0;
    logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = 4'hF;
    logic [31:0]  prdata;
    logic         pready, pslverr;
    logic [1:0]   q_en, q_doorbell;
    logic [7:0]   q_log_size;
    logic [127:0] q_base_addr;
    logic [31:0]  q_prod;
    logic [31:0]  q_cons = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        string       name;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    cndm_micro_dp_ctrl_apb #(
        .QUEUES(2), .ADDR_W(16), .WAIT_STATES(1), .MAX_LOG_SIZE(14)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
        .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
        .s_apb_prdata(prdata), .s_apb_pready(pready), .s_apb_pslverr(pslverr),
        .q_en(q_en), .q_log_size(q_log_size), .q_base_addr(q_base_addr),
        .q_prod(q_prod), .q_doorbell(q_doorbell), .q_cons(q_cons)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pready === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pready: got pready=1 expected no transfer");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_rdata"}, prdata, e.d);
                chk({e.name, "_pslverr"}, pslverr, e.e);
            end
        end else begin
            chk("idle_resp_zero", {prdata, pslverr}, 33'h0);
        end
    end

    task automatic apb(input string name, input logic [15:0] a, input logic w,
                       input logic [31:0] d, input logic [31:0] er, input logic ee);
        int n;
        @(posedge clk); #1;
        paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
        sbq.push_back('{er, ee, name});
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pready !== 1'b1 && n < 10);
        chk({name, "_latency"}, n, 2);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_q_en", q_en, 0);
        chk("rst_q_prod", q_prod, 0);
        chk("rst_q_base", q_base_addr, 0);
        chk("rst_outputs", {pready, pslverr, prdata, q_doorbell, q_log_size}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        apb("rd_id", 16'h0000, 0, 0, 32'h0002_0001, 0);

        apb("wr_ctrl0", 16'h0100, 1, 32'h000C_0001, 0, 0);
        chk("q_en_after_ctrl", q_en, 2'b01);
        chk("q_log_after_ctrl", q_log_size, 8'h0C);
        apb("rd_ctrl0", 16'h0100, 0, 0, 32'h000C_0001, 0);

        apb("wr_base_locked", 16'h0104, 1, 32'hDEAD_0000, 0, 1);
        chk("base_unchanged", q_base_addr, 0);
        apb("wr_disable", 16'h0100, 1, 32'h000C_0000, 0, 0);
        chk("q_en_disabled", q_en, 2'b00);
        apb("wr_base_lo", 16'h0104, 1, 32'hDEAD_0000, 0, 0);
        apb("wr_base_hi", 16'h010A, 1, 32'h1234_5678, 0, 0);
        chk("base_written", q_base_addr, 128'h1234_5678_DEAD_0000);
        apb("rd_base_lo", 16'h0104, 0, 0, 32'hDEAD_0000, 0);
        apb("rd_ctrl0_off", 16'h0100, 0, 0, 32'h000C_0000, 0);

        apb("wr_prod1", 16'h012C, 1, 32'h0000_0005, 0, 0);
        chk("q_prod1", q_prod, {16'd5, 16'd0});
        @(negedge clk);
        chk("doorbell_pulse", q_doorbell, 2'b10);
        @(negedge clk);
        chk("doorbell_cleared", q_doorbell, 2'b00);
        q_cons = {16'd3, 16'd9};
        apb("rd_cons1", 16'h0130, 0, 0, 32'd3, 0);
        apb("rd_cons0", 16'h0110, 0, 0, 32'd9, 0);

        apb("wr_unmapped", 16'h0200, 1, 32'hFFFF_FFFF, 0, 1);
        apb("rd_unmapped", 16'h0200, 0, 0, 0, 1);
        apb("rd_hole", 16'h0114, 0, 0, 0, 1);
        apb("wr_ctrl_bigsize", 16'h0120, 1, 32'h000F_0001, 0, 1);
        chk("bigsize_no_en", q_en, 2'b00);
        chk("bigsize_no_log", q_log_size, 8'h0C);
        apb("wr_ro_id", 16'h0000, 1, 32'h1, 0, 1);
        apb("wr_ro_cons", 16'h0130, 1, 32'h7, 0, 1);
        apb("wr_ctrl_maxsize", 16'h0120, 1, 32'h000E_0000, 0, 0);
        chk("maxsize_log", q_log_size, 8'hEC);
        chk("ctrl_keeps_prod", q_prod, {16'd5, 16'd0});

        // Reset hits while a PROD write sits in its wait state.
        @(posedge clk); #1;
        paddr = 16'h010C; pwrite = 1'b1; pwdata = 32'd7; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_doorbell", q_doorbell, 2'b00);
            chk("rst_mid_pready", pready, 1'b0);
        end
        chk("rst_mid_prod", q_prod, 0);
        chk("rst_mid_cfg", {q_en, q_log_size, q_base_addr}, 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_prod", q_prod, 0);
        apb("rd_id_after_rst", 16'h0000, 0, 0, 32'h0002_0001, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
